countdown_timer: RTL
====================

# countdown_timer

- Parametrised countdown timer; next generation of the team's fixed 4-bit seconds timer.
- Counts a loaded value down once per second, derived from a configurable clock frequency.
- Emits aligned 1 Hz / 2 Hz enable pulses and an expiry level and pulse.
- Adds pause/resume, clear, an IDLE/RUN/PAUSE/DONE state machine and optional auto-reload; feeds the FSMs and display drivers in the top level.

## Interface
- CLK_HZ, 100_000_000, clock frequency in Hz; must be even and ≥ 4; HALF = CLK_HZ/2
- COUNT_W, 8, width of load value and counter (1..16)
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  load value and run; highest priority after reset
- value  in  COUNT_W  seconds to count, sampled when start=1
- pause  in  1  level; freezes timer while high in RUN
- clear  in  1  return to IDLE, counter to 0
- auto_reload  in  1  repeat mode (effective only with macro, see Configuration)
- counter  out  COUNT_W  remaining seconds
- one_hz_enable  out  1  one-cycle pulse each second boundary in RUN
- two_hz_enable  out  1  one-cycle pulse each half-second boundary in RUN
- expired  out  1  level, high in DONE
- expired_pulse  out  1  one-cycle pulse on each reach-zero event
- state  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE

## Operation
- Reset (reset=0, async): state IDLE, counter 0, prescaler 0, phase 0, all pulse/level outputs 0.
- Priority per edge: start > clear > pause > counting.
- start: counter←value, reload register←value, prescaler←0, phase←0, pulses forced 0.
  - Next state RUN if value≠0.
  - If value=0: next state DONE, expired_pulse high one cycle.
  - Legal from any state; restarts a running timer.
- clear: state IDLE, counter 0, prescaler 0, pulses 0; ignored in IDLE.
- RUN:
  - Prescaler counts 0..HALF-1 and wraps.
  - At wrap: two_hz_enable pulses and phase toggles.
  - When phase was 1 at wrap: one_hz_enable also pulses and counter decrements.
  - Decrement from 1 to 0: expired_pulse pulses on the same edge and state→DONE.
- PAUSE:
  - Entered from RUN while pause=1; returns to RUN when pause=0.
  - Prescaler, phase and counter frozen; no pulses.
  - Resume continues from the frozen prescaler value; the period remainder is not lost.
  - pause in IDLE/DONE is ignored.
- DONE: expired=1, counter 0, no pulses; exits only on start, clear or reset.
- Counter never underflows; no decrement occurs at 0.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- Start sampled at edge k:
  - state and counter update at edge k.
  - First two_hz_enable is high after edge k+HALF.
  - First one_hz_enable and first decrement after edge k+CLK_HZ.
  - Later pulses follow every HALF and CLK_HZ edges respectively.
- With value=N≠0, uninterrupted:
  - expired_pulse and DONE after edge k+N·CLK_HZ.
  - expired=1 from that edge on.
- Each pulse is exactly one cycle wide.
- Pause for P cycles delays all subsequent events by exactly P cycles.
- Reset mid-count takes effect immediately and asynchronously; the first edge after release behaves as IDLE.

## Configuration
- Macro: COUNTDOWN_TIMER_AUTORELOAD_EN.
- Defined:
  - If auto_reload=1 at a reach-zero edge, counter←reload register and state stays RUN.
  - expired_pulse still pulses; expired stays 0.
  - Prescaler and phase continue unbroken, so the period is exactly reload·CLK_HZ.
  - If the reload value is 0, the block goes to DONE instead.
- Undefined: auto_reload port present but ignored; reach-zero always enters DONE.

## Test plan
- CLK_HZ=8, COUNT_W=4:
  - Reset, start with value=3.
  - Required: two_hz_enable after edges k+4, k+8, …; one_hz_enable after k+8, k+16, k+24.
  - Required: counter 3→2→1→0; expired_pulse and expired after k+24; state=3.
- Start with value=0: state DONE and expired_pulse after edge k; no enable pulses ever.
- value=2 with pause high for 5 cycles starting at k+6:
  - Required: state=2 during pause, outputs frozen.
  - Required: first one_hz_enable after k+13, expiry after k+21.
- Restart and clear:
  - Re-assert start with value=5 at k+10 during a count of 3: counter=5, prescaler restarted, expiry after k+10+40.
  - clear mid-count → IDLE, counter 0.
- Reset driven low asynchronously mid-RUN (between edges): all outputs 0 immediately, IDLE.
- With COUNTDOWN_TIMER_AUTORELOAD_EN defined, auto_reload=1, value=2:
  - Required: expired_pulse after k+16, k+32, k+48; counter reloads to 2; expired stays 0.
- Without the macro: the same stimulus ends in DONE after k+16.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: master drives the controls,
// slave (the timer) drives the count, enable pulses, expiry and state.
interface countdown_timer_if #(
   parameter int COUNT_W = 8
);
   logic               start;
   logic [COUNT_W-1:0] value;
   logic               pause;
   logic               clear;
   logic               auto_reload;
   logic [COUNT_W-1:0] counter;
   logic               one_hz_enable;
   logic               two_hz_enable;
   logic               expired;
   logic               expired_pulse;
   logic [1:0]         state;

   modport master (
      output start, value, pause, clear, auto_reload,
      input  counter, one_hz_enable, two_hz_enable, expired, expired_pulse, state
   );

   modport slave (
      input  start, value, pause, clear, auto_reload,
      output counter, one_hz_enable, two_hz_enable, expired, expired_pulse, state
   );
endinterface

// File: rtl/countdown_timer.sv
// Seconds countdown timer with aligned 1 Hz / 2 Hz enables, pause, clear and expiry.
// Optional repeat mode is compiled in with COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int COUNT_W = 8
) (
   input logic              clock,
   input logic              reset,
   countdown_timer_if.slave bus
);
   localparam int HALF    = CLK_HZ / 2;
   localparam int PRESC_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [COUNT_W-1:0] counter_q, counter_d;
   logic [COUNT_W-1:0] reload_q, reload_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               phase_q, phase_d;
   logic               one_q, one_d;
   logic               two_q, two_d;
   logic               expp_q, expp_d;
   logic               reloadEn;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
   assign reloadEn = bus.auto_reload && (reload_q != '0);
`else
   logic unusedAutoReload;
   assign unusedAutoReload = bus.auto_reload;
   assign reloadEn         = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         counter_q <= '0;
         reload_q  <= '0;
         presc_q   <= '0;
         phase_q   <= 1'b0;
         one_q     <= 1'b0;
         two_q     <= 1'b0;
         expp_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         reload_q  <= reload_d;
         presc_q   <= presc_d;
         phase_q   <= phase_d;
         one_q     <= one_d;
         two_q     <= two_d;
         expp_q    <= expp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      reload_d  = reload_q;
      presc_d   = presc_q;
      phase_d   = phase_q;
      one_d     = 1'b0;
      two_d     = 1'b0;
      expp_d    = 1'b0;

      if (bus.start) begin
         counter_d = bus.value;
         reload_d  = bus.value;
         presc_d   = '0;
         phase_d   = 1'b0;
         if (bus.value != '0) begin
            state_d = RUN;
         end else begin
            state_d = DONE;
            expp_d  = 1'b1;
         end
      end else if (bus.clear && state_q != IDLE) begin
         state_d   = IDLE;
         counter_d = '0;
         presc_d   = '0;
         phase_d   = 1'b0;
      end else if (state_q == RUN && bus.pause) begin
         state_d = PAUSE;
      end else if (state_q == RUN || (state_q == PAUSE && !bus.pause)) begin
         // The resume edge counts, so a pause of P cycles costs exactly P cycles.
         state_d = RUN;
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            phase_d = ~phase_q;
            two_d   = 1'b1;
            if (phase_q && counter_q != '0) begin
               one_d     = 1'b1;
               counter_d = counter_q - COUNT_W'(1);
               if (counter_q == COUNT_W'(1)) begin
                  expp_d = 1'b1;
                  if (reloadEn) begin
                     counter_d = reload_q;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
         end else begin
            presc_d = presc_q + PRESC_W'(1);
         end
      end
   end

   assign bus.counter       = counter_q;
   assign bus.one_hz_enable = one_q;
   assign bus.two_hz_enable = two_q;
   assign bus.expired       = (state_q == DONE);
   assign bus.expired_pulse = expp_q;
   assign bus.state         = state_q;
endmodule
